// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind an in-order request FIFO with programmable wait states.
// Define DMEM_STATS_EN to add load/store/drop counter outputs.
module data_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int LATENCY   = 2,
  parameter int REQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ack,
  output logic [31:0] mem_read_val,
  output logic        busy,
  input  logic        err_clr,
  output logic        err_misaligned,
  output logic        err_overflow
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_drops
`endif
);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    LAT  = 4'(LATENCY);
  localparam logic [CW-1:0] FULL = CW'(REQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic [31:0]   read_val_q, read_val_d;
  logic          err_mis_q, err_mis_d, err_ovf_q, err_ovf_d;

  logic          fifo_we   [REQ_DEPTH];
  logic [AW+1:0] fifo_addr [REQ_DEPTH];
  logic [31:0]   fifo_data [REQ_DEPTH];
  logic [31:0]   mem       [DEPTH];

  logic          full, fire, push, drop, mem_wr;
  logic          head_we, head_mis;
  logic [AW+1:0] head_addr;
  logic [AW-1:0] head_idx;
  logic [31:0]   head_data;
  logic          unused_addr_hi;

  // Upper address bits alias; only the word index and byte offset are kept.
  assign unused_addr_hi = ^mem_addr[31:AW+2];

  assign head_we   = fifo_we[rd_ptr_q];
  assign head_addr = fifo_addr[rd_ptr_q];
  assign head_data = fifo_data[rd_ptr_q];
  assign head_idx  = head_addr[AW+1:2];
  assign head_mis  = |head_addr[1:0];

  // The head stays queued while in service and is popped on its ack edge,
  // so a push at that same edge still fits into a full FIFO.
  assign fire   = (state_q == WAIT) && (cnt_q == LAT);
  assign full   = (count_q == FULL);
  assign push   = mem_req && (!full || fire);
  assign drop   = mem_req && full && !fire;
  assign mem_wr = fire && head_we && !head_mis;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(fire);
    count_d    = count_q + CW'(push) - CW'(fire);
    ack_d      = fire;
    read_val_d = read_val_q;
    err_mis_d  = err_mis_q & ~err_clr;
    err_ovf_d  = err_ovf_q & ~err_clr;
    if (fire && head_mis) err_mis_d = 1'b1;
    if (drop)             err_ovf_d = 1'b1;
    if (fire)             read_val_d = (head_we || head_mis) ? 32'd0 : mem[head_idx];
    case (state_q)
      WAIT: begin
        if (fire) begin
          // Next entry (already queued or pushed now) starts service on this edge.
          if (count_d != '0) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        if (push || count_q != '0) begin
          state_d = WAIT;
          cnt_d   = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      read_val_q <= '0;
      err_mis_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      read_val_q <= read_val_d;
      err_mis_q  <= err_mis_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr_q]   <= mem_we;
      fifo_addr[wr_ptr_q] <= mem_addr[AW+1:0];
      fifo_data[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[head_idx] <= head_data;
  end

  assign mem_ack        = ack_q;
  assign mem_read_val   = read_val_q;
  assign busy           = (count_q != '0) || (state_q == WAIT);
  assign err_misaligned = err_mis_q;
  assign err_overflow   = err_ovf_q;

`ifdef DMEM_STATS_EN
  logic [31:0] loads_q, loads_d, stores_q, stores_d, drops_q, drops_d;

  always_comb begin
    loads_d  = loads_q + 32'(fire && !head_we);
    stores_d = stores_q + 32'(fire && head_we);
    drops_d  = drops_q + 32'(drop);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      drops_q  <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      drops_q  <= drops_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances with LATENCY 1..4 share one stimulus bus
// and are checked every cycle against a timestamp-based request model.
module tb_data_mem_responder;
  localparam int ND  = 4;
  localparam int RQD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0, err_clr = 1'b0;
  logic [31:0] mem_addr = '0, mem_data = '0;
  logic [ND-1:0] ack, busy, emis, eovf;
  logic [31:0] rv [ND];
`ifdef DMEM_STATS_EN
  logic [31:0] st_ld [ND], st_st [ND], st_dr [ND];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(g + 1), .REQ_DEPTH(RQD)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ack(ack[g]), .mem_read_val(rv[g]), .busy(busy[g]),
      .err_clr(err_clr), .err_misaligned(emis[g]), .err_overflow(eovf[g])
`ifdef DMEM_STATS_EN
      , .stat_loads(st_ld[g]), .stat_stores(st_st[g]), .stat_drops(st_dr[g])
`endif
    );
  end

  // Model: every accepted request gets an ack edge = max(push edge, previous ack edge) + L.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_t;
  } mreq_t;

  mreq_t       mq [ND][$];
  logic [31:0] mmem [ND][1024];
  logic        m_ack [ND];
  logic [31:0] m_rv [ND];
  logic        m_mis [ND], m_ovf [ND];
  logic [31:0] m_ld [ND], m_st [ND], m_dr [ND];
  int          cyc = 0;
  bit          mdl_ready = 1'b0;
  int          n_chk = 0, n_err = 0;

  task automatic model_edge();
    mreq_t r;
    int    occ;
    bit    pop;
    cyc++;
    mdl_ready = 1'b1;
    for (int d = 0; d < ND; d++) begin
      m_ack[d] = 1'b0;
      if (rst_n) begin
        mq[d].delete();
        m_rv[d] = '0; m_mis[d] = 1'b0; m_ovf[d] = 1'b0;
        m_ld[d] = '0; m_st[d] = '0; m_dr[d] = '0;
      end else begin
        occ = mq[d].size();
        pop = (occ > 0) && (mq[d][0].ack_t == cyc);
        if (err_clr) begin m_mis[d] = 1'b0; m_ovf[d] = 1'b0; end
        if (pop) begin
          r = mq[d].pop_front();
          m_ack[d] = 1'b1;
          if (r.addr[1:0] != 2'b00) begin
            m_mis[d] = 1'b1;
            m_rv[d]  = '0;
          end else if (r.we) begin
            mmem[d][r.addr[11:2]] = r.data;
            m_rv[d] = '0;
          end else begin
            m_rv[d] = mmem[d][r.addr[11:2]];
          end
          if (r.we) m_st[d] = m_st[d] + 1; else m_ld[d] = m_ld[d] + 1;
        end
        if (mem_req) begin
          if (occ < RQD || pop) begin
            r.we = mem_we; r.addr = mem_addr; r.data = mem_data;
            r.ack_t = ((mq[d].size() > 0) ? mq[d][$].ack_t : cyc) + d + 1;
            mq[d].push_back(r);
          end else begin
            m_ovf[d] = 1'b1;
            m_dr[d]  = m_dr[d] + 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_edge();

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d (L=%0d) t=%0t: got %h expected %h", nm, d, d + 1, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    if (!mdl_ready) return;
    for (int d = 0; d < ND; d++) begin
      chk("ack", d, 32'(ack[d]), 32'(m_ack[d]));
      chk("busy", d, 32'(busy[d]), 32'(mq[d].size() > 0));
      chk("read_val", d, rv[d], m_rv[d]);
      chk("err_misaligned", d, 32'(emis[d]), 32'(m_mis[d]));
      chk("err_overflow", d, 32'(eovf[d]), 32'(m_ovf[d]));
`ifdef DMEM_STATS_EN
      chk("stat_loads", d, st_ld[d], m_ld[d]);
      chk("stat_stores", d, st_st[d], m_st[d]);
      chk("stat_drops", d, st_dr[d], m_dr[d]);
`endif
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic we, input logic [31:0] a, input logic [31:0] dt);
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_data = dt;
    step();
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  logic [31:0] seq_addr [6];
  logic [31:0] seq_data [6];
  logic        seq_we   [6];
  int          nack;

  initial begin
    idle(3);
    for (int d = 0; d < ND; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 32'd0);
      chk("rst_read_val", d, rv[d], 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_errs", d, {30'd0, emis[d], eovf[d]}, 32'd0);
    end
    rst_n = 1'b0;
    idle(2);

    // Basic store then load; L=2 acks two edges after the sample edge.
    pulse(1'b1, 32'h10, 32'hDEADBEEF);
    step();
    chk("t1_ack_L1", 0, 32'(ack[0]), 32'd1);
    chk("t1_noack_L2", 1, 32'(ack[1]), 32'd0);
    step();
    chk("t1_store_ack", 1, 32'(ack[1]), 32'd1);
    chk("t1_store_rv", 1, rv[1], 32'd0);
    idle(6);
    pulse(1'b0, 32'h10, 32'h0);
    idle(2);
    chk("t1_load_ack", 1, 32'(ack[1]), 32'd1);
    chk("t1_load_rv", 1, rv[1], 32'hDEADBEEF);
    idle(6);

    // Six back-to-back requests: L=4 with 4-deep FIFO keeps five, drops one.
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100 + 32'(4 * i); mem_data = 32'hC0DE0000 + 32'(i);
      step();
      nack += int'(ack[3]);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      nack += int'(ack[3]);
    end
    chk("t2_ack_count", 3, 32'(nack), 32'd5);
    chk("t2_overflow", 3, 32'(eovf[3]), 32'd1);
    chk("t2_no_overflow_L1", 0, 32'(eovf[0]), 32'd0);
`ifdef DMEM_STATS_EN
    chk("t2_stat_drops", 3, st_dr[3], 32'd1);
`endif

    // LATENCY=1 sustains one ack per cycle.
    clr_pulse();
    seq_we[0] = 1'b1; seq_addr[0] = 32'h0; seq_data[0] = 32'h11111111;
    seq_we[1] = 1'b1; seq_addr[1] = 32'h4; seq_data[1] = 32'h22222222;
    seq_we[2] = 1'b1; seq_addr[2] = 32'h8; seq_data[2] = 32'h33333333;
    for (int i = 3; i < 6; i++) begin
      seq_we[i] = 1'b0; seq_addr[i] = seq_addr[i-3]; seq_data[i] = 32'h0;
    end
    for (int i = 0; i < 6; i++) begin
      mem_req = 1'b1; mem_we = seq_we[i]; mem_addr = seq_addr[i]; mem_data = seq_data[i];
      step();
      if (i >= 1) chk("t3_ack", 0, 32'(ack[0]), 32'd1);
      if (i >= 4) chk("t3_load_rv", 0, rv[0], seq_data[i-4]);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("t3_last_ack", 0, 32'(ack[0]), 32'd1);
    chk("t3_last_rv", 0, rv[0], 32'h33333333);
    chk("t3_no_overflow", 0, 32'(eovf[0]), 32'd0);
    step();
    chk("t3_ack_done", 0, 32'(ack[0]), 32'd0);
    idle(30);

    // Misaligned store does not write; err_clr clears; misaligned load returns 0.
    clr_pulse();
    pulse(1'b1, 32'h0, 32'h12345678);
    idle(6);
    pulse(1'b1, 32'h3, 32'h55);
    idle(6);
    chk("t4_mis_set", 1, 32'(emis[1]), 32'd1);
    clr_pulse();
    chk("t4_mis_clr", 1, 32'(emis[1]), 32'd0);
    pulse(1'b0, 32'h0, 32'h0);
    idle(6);
    chk("t4_word0_kept", 1, rv[1], 32'h12345678);
    pulse(1'b0, 32'h2, 32'h0);
    idle(6);
    chk("t4_mis_load_rv", 1, rv[1], 32'd0);
    chk("t4_mis_again", 1, 32'(emis[1]), 32'd1);

    // Address aliasing modulo DEPTH*4.
    pulse(1'b1, 32'h1000, 32'hA5A5A5A5);
    idle(6);
    pulse(1'b0, 32'h0, 32'h0);
    idle(6);
    chk("t5_alias", 1, rv[1], 32'hA5A5A5A5);
    chk("t5_alias", 3, rv[3], 32'hA5A5A5A5);

    // Reset mid-service discards the pending store and load.
    pulse(1'b1, 32'h0, 32'h0BAD0BAD);
    pulse(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    idle(2);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_no_ack", 2, 32'(ack[2]), 32'd0);
      chk("t6_busy", 2, 32'(busy[2]), 32'd0);
    end
    chk("t6_mis_cleared", 1, 32'(emis[1]), 32'd0);
    pulse(1'b0, 32'h0, 32'h0);
    idle(6);
    chk("t6_mem_kept", 2, rv[2], 32'hA5A5A5A5);
    chk("t6_mem_kept", 1, rv[1], 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the load/store unit's memory port (mem_req/mem_we/mem_addr/mem_data in, mem_ack/mem_read_val out).
- Models word-addressed data memory with programmable wait states and a small in-order request buffer, so single-cycle mem_req pulses are never lost while a request is in service.
- Sits between the LSQ and the data RAM. Serves as both the synthesizable data memory and the LSQ's bench counterpart.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- AW, 10, word-index width (log2 DEPTH).
- LATENCY, 2, cycles from service start to mem_ack; legal range 1..15.
- REQ_DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (block is in reset while rst_n=1).
- mem_req  in  1  request strobe, sampled each rising edge; no ready/backpressure.
- mem_we  in  1  1 = store, 0 = load; qualified by mem_req.
- mem_addr  in  32  byte address.
- mem_data  in  32  store data.
- mem_ack  out  1  one-cycle completion pulse.
- mem_read_val  out  32  load data, valid while mem_ack=1; 0 for stores.
- busy  out  1  FIFO non-empty or a request in service.
- err_clr  in  1  clears both sticky error flags.
- err_misaligned  out  1  sticky: a serviced request had mem_addr[1:0] != 0.
- err_overflow  out  1  sticky: a request was dropped because the FIFO was full.

Behaviour:
- Reset values: mem_ack=0, mem_read_val=0, busy=0, err_misaligned=0, err_overflow=0. FIFO is emptied and the latency counter cleared.
- Memory array contents are NOT reset. Unwritten words read as X.
- Reset mid-service: the pending request and all queued requests are discarded, no ack is issued, and no write occurs.
- Enqueue: at each edge with mem_req=1, {we, addr, data} is pushed to the FIFO.
  - If the FIFO is full and no pop happens at the same edge, the request is dropped and err_overflow is set.
  - A simultaneous push and pop at full is accepted, with no overflow.
- States: IDLE, WAIT, ACK.
  - IDLE -> WAIT when the FIFO is non-empty. A request pushed into an empty FIFO while in IDLE starts service at its own push edge (bypass).
  - WAIT: the counter counts to LATENCY, then -> ACK.
  - ACK: mem_ack=1 for exactly one cycle and the head is popped. Then -> WAIT if another entry is present (its service starts at the ACK edge), else -> IDLE.
- Timing:
  - Request sampled at edge n with the block idle: mem_ack is high during the cycle after edge n+LATENCY.
  - Queued request: its ack comes LATENCY edges after the previous ack edge.
  - LATENCY=1 sustains one ack per cycle with back-to-back requests.
- Store:
  - The word at index mem_addr[AW+1:2] is written at the ack edge.
  - mem_read_val=0 during the ack cycle.
  - Address bits above AW+1 are ignored, so addresses alias modulo DEPTH*4.
- Load: mem_read_val = word at mem_addr[AW+1:2], sampled at the ack edge. Strict in-order service, so a load after a store to the same word returns the stored data.
- Misaligned request (addr[1:0] != 0):
  - It is still acked, and err_misaligned is set.
  - A misaligned store performs no write.
  - A misaligned load returns 0.
- mem_read_val holds its last value while mem_ack=0.
- err_clr clears both flags at the edge where it is sampled. A same-edge set takes priority over the clear.
- busy is combinational from state and FIFO occupancy.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined, adds three output ports, each 32 bits, reset to 0, wrapping at 2^32:
  - stat_loads: loads acked.
  - stat_stores: stores acked.
  - stat_drops: requests dropped on overflow.
- When not defined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- LATENCY=2, idle: store addr 0x10 data 0xDEADBEEF at edge 5 -> mem_ack in cycle after edge 7 with mem_read_val=0. Load 0x10 at edge 9 -> ack after edge 11 with mem_read_val=0xDEADBEEF.
- LATENCY=1: stores to 0x0, 0x4, 0x8 on consecutive edges, then 3 loads -> six acks on six consecutive cycles; loads return the stored values in order; err_overflow=0.
- LATENCY=4, REQ_DEPTH=4: six single-cycle req pulses on consecutive edges -> exactly 5 acks (4 queued plus the one popped early enough), err_overflow=1; with DMEM_STATS_EN, stat_drops=1.
- Store 0x3 data 0x55 -> ack, err_misaligned=1, word 0 unchanged. err_clr pulse -> flag=0. Load 0x2 -> mem_read_val=0, flag set again.
- Aliasing, DEPTH=1024: store 0x1000 data 0xA5A5A5A5 -> load 0x0 returns 0xA5A5A5A5.
- Assert rst_n=1 one cycle after a load req with LATENCY=3 -> no mem_ack for 10 cycles after release, busy=0, previously stored memory data still readable.
